// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with Start/Busy/Done handshake.
// Optional `BOOTH_UNSIGNED_EN adds an IsSigned input selecting unsigned operands.
module booth_seq_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 IsSigned,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [WIDTH:0]       a, m_reg, sum;
  logic [QW-1:0]        q;
  logic                 q_1;
  logic [CNT_W-1:0]     count;
  logic [WIDTH:0]       m_load;
  logic [QW-1:0]        q_load;
  logic [CNT_W-1:0]     cnt_load;
  logic [2*WIDTH-1:0]   prod_fin;
  logic                 last_iter;
`ifdef BOOTH_UNSIGNED_EN
  logic                 signed_r;
`endif

  assign last_iter = (count == CNT_W'(1));

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN; else state_next = IDLE;
      RUN:     if (last_iter) state_next = DONE; else state_next = RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand extension on load; unsigned mode needs one extra iteration.
  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    if (IsSigned) begin
      m_load   = {Multiplicand[WIDTH-1], Multiplicand};
      q_load   = {Multiplier[WIDTH-1], Multiplier};
      cnt_load = CNT_W'(WIDTH);
    end else begin
      m_load   = {1'b0, Multiplicand};
      q_load   = {1'b0, Multiplier};
      cnt_load = CNT_W'(WIDTH + 1);
    end
`else
    m_load   = {Multiplicand[WIDTH-1], Multiplicand};
    q_load   = Multiplier;
    cnt_load = CNT_W'(WIDTH);
`endif
  end

  // Booth add/subtract and the post-shift product taken on the last iteration.
  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m_reg;
      2'b10:   sum = a - m_reg;
      default: sum = a;
    endcase
    // {sum, q} shifted right by one: A'[W-1:0] = sum[W:1], Q' = {sum[0], q[QW-1:1]}
`ifdef BOOTH_UNSIGNED_EN
    if (signed_r) prod_fin = {sum, q[QW-1:2]};
    else          prod_fin = {sum[WIDTH-1:0], q[QW-1:1]};
`else
    prod_fin = {sum, q[QW-1:1]};
`endif
  end

  // Datapath registers and registered handshake outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a        <= '0;
      m_reg    <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      count    <= '0;
      Product  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      signed_r <= 1'b0;
`endif
    end else begin
      Busy <= (state_next != IDLE);
      Done <= (state_next == DONE);
      if (state == IDLE && Start) begin
        a     <= '0;
        m_reg <= m_load;
        q     <= q_load;
        q_1   <= 1'b0;
        count <= cnt_load;
`ifdef BOOTH_UNSIGNED_EN
        signed_r <= IsSigned;
`endif
      end else if (state == RUN) begin
        a     <= {sum[WIDTH], sum[WIDTH:1]};
        q     <= {sum[0], q[QW-1:1]};
        q_1   <= q[0];
        count <= count - CNT_W'(1);
        if (last_iter) Product <= prod_fin;
        else           Product <= Product;
      end else begin
        a <= a;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult (WIDTH=8).
// Covers the unsigned vectors too when built with BOOTH_UNSIGNED_EN.
module tb_booth_seq_mult;
  localparam int W = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [W-1:0]  Multiplicand = '0;
  logic [W-1:0]  Multiplier = '0;
  logic          is_signed = 1'b1;
  logic          Busy, Done;
  logic [2*W-1:0] Product;

  int checks = 0;
  int errors = 0;

  booth_seq_mult #(.WIDTH(W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Multiplicand(Multiplicand),
    .Multiplier(Multiplier),
`ifdef BOOTH_UNSIGNED_EN
    .IsSigned(is_signed),
`endif
    .Busy(Busy),
    .Done(Done),
    .Product(Product)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one multiply and check busy, latency, product and the one-cycle Done pulse.
  task automatic run_mult(input string tag, input logic [7:0] m, input logic [7:0] q,
                          input logic sgn, input logic [15:0] exp, input int lat);
    int cyc;
    @(negedge Clock);
    Multiplicand = m;
    Multiplier   = q;
    is_signed    = sgn;
    Start        = 1'b1;
    @(negedge Clock);
    Start        = 1'b0;
    Multiplicand = ~m;
    Multiplier   = 8'h5A;
    is_signed    = ~sgn;
    check_val({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    cyc = 1;
    while (!Done && cyc < 30) begin
      @(negedge Clock);
      cyc++;
    end
    check_val({tag, "_latency"}, cyc, lat);
    check_val({tag, "_product"}, {16'd0, Product}, {16'd0, exp});
    @(negedge Clock);
    check_val({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    check_val({tag, "_idle"}, {31'd0, Busy}, 32'd0);
    check_val({tag, "_hold"}, {16'd0, Product}, {16'd0, exp});
  endtask

  initial begin
    int cyc;
    #2;
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_done", {31'd0, Done}, 32'd0);
    check_val("rst_product", {16'd0, Product}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    run_mult("m3q5",     8'h03, 8'h05, 1'b1, 16'h000F, W + 1);
    run_mult("mn7q6",    8'hF9, 8'h06, 1'b1, 16'hFFD6, W + 1);
    run_mult("m127qn128",8'h7F, 8'h80, 1'b1, 16'hC080, W + 1);
    run_mult("mminsq",   8'h80, 8'h80, 1'b1, 16'h4000, W + 1);
    run_mult("m0qn1",    8'h00, 8'hFF, 1'b1, 16'h0000, W + 1);
    run_mult("mn1qn1",   8'hFF, 8'hFF, 1'b1, 16'h0001, W + 1);

    // Start pulses during RUN and during DONE must be ignored.
    @(negedge Clock);
    Multiplicand = 8'h05; Multiplier = 8'h09; is_signed = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 30) begin
      if (cyc == 3) begin
        Multiplicand = 8'h10; Multiplier = 8'h10; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    check_val("ign_latency", cyc, W + 1);
    check_val("ign_product", {16'd0, Product}, 32'h002D);
    Multiplicand = 8'h20; Multiplier = 8'h20; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check_val("ign_done_once", {31'd0, Done}, 32'd0);
    check_val("ign_idle", {31'd0, Busy}, 32'd0);
    @(negedge Clock);
    check_val("ign_still_idle", {31'd0, Busy}, 32'd0);
    check_val("ign_hold", {16'd0, Product}, 32'h002D);

    // Asynchronous reset in the fourth RUN cycle aborts the operation.
    Multiplicand = 8'h03; Multiplier = 8'h05; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    #1 Reset = 1'b1;
    #1;
    check_val("arst_busy", {31'd0, Busy}, 32'd0);
    check_val("arst_done", {31'd0, Done}, 32'd0);
    check_val("arst_product", {16'd0, Product}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (12) begin
      @(negedge Clock);
      check_val("arst_no_done", {31'd0, Done}, 32'd0);
    end
    run_mult("post_rst", 8'h03, 8'h05, 1'b1, 16'h000F, W + 1);

`ifdef BOOTH_UNSIGNED_EN
    run_mult("uns_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, W + 2);
    run_mult("sgn_ff",   8'hFF, 8'hFF, 1'b1, 16'h0001, W + 1);
    run_mult("uns_80",   8'h80, 8'h80, 1'b0, 16'h4000, W + 2);
    run_mult("uns_f9",   8'hF9, 8'h06, 1'b0, 16'h05D6, W + 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Parametrised sequential radix-2 Booth multiplier. The datapath and control are self-contained: accumulator, multiplier shift register, Booth bit, iteration counter and FSM.
- Replaces the hand-sequenced Load/Shift shift-register datapath with a single-clock design that runs itself.
- Uses a Start/Busy/Done handshake.
- Sits between operand registers and the result bus of the arithmetic unit.
- Signed two's-complement by default.

Parameters:
WIDTH, 8, operand width in bits (>= 2); Product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override)

Ports:
Clock         input   1          rising-edge clock
Reset         input   1          asynchronous, active-high reset
Start         input   1          request a multiply; sampled only in IDLE
Multiplicand  input   WIDTH      operand M, captured on accepted Start
Multiplier    input   WIDTH      operand Q, captured on accepted Start
Busy          output  1          high in RUN and DONE
Done          output  1          one-cycle pulse; Product valid
Product       output  2*WIDTH    result; holds until the next accepted Start

Behaviour:
- Reset is asynchronous and active-high. While Reset is asserted:
  - state = IDLE;
  - A, Q, Q_1, count, Product = 0;
  - Busy = 0, Done = 0.
  - Reset asserted mid-operation aborts the operation; no Done is produced.
- Registers:
  - A: WIDTH+1-bit signed accumulator (the extra bit covers M = -2^(WIDTH-1));
  - Mreg: WIDTH+1 bits, sign-extended;
  - Q: WIDTH bits;
  - Q_1: 1 bit;
  - count.
- FSM, IDLE:
  - Start=1 → capture Mreg=sext(Multiplicand), Q=Multiplier, A=0, Q_1=0, count=WIDTH; go to RUN.
  - Start=0 → stay in IDLE.
- FSM, RUN, one Booth iteration per clock:
  - {Q[0],Q_1}=01 → A+Mreg; 10 → A-Mreg; 00/11 → A unchanged.
  - Then arithmetic right shift of {A,Q,Q_1} by 1, replicating the MSB of the post-add A.
  - count decrements.
  - When the iteration with count==1 completes, load Product = {A[WIDTH-1:0], Q} (post-shift) and go to DONE.
- FSM, DONE: Done=1 for exactly one cycle, then go to IDLE.
- Latency: accepted Start edge → WIDTH clocks in RUN → Done high on cycle WIDTH+1. Next Start is accepted in the cycle after Done at the earliest, so throughput is one result per WIDTH+2 cycles.
- Start while Busy=1, including the DONE cycle, is ignored; operands are not re-sampled.
- Operand inputs may change freely after acceptance.
- Product changes only on the final RUN→DONE edge and on Reset. Between operations it holds its last value.
- Arithmetic wraps modulo 2^(WIDTH+1) inside A; the final 2*WIDTH result is exact for all signed operand pairs, including -2^(WIDTH-1) × -2^(WIDTH-1).
- Busy = (state != IDLE). Done = (state == DONE).
- No X on any output after Reset deasserts.

Optional Feature:
BOOTH_UNSIGNED_EN
- Defined:
  - Adds input port IsSigned (1 bit), captured with the operands on an accepted Start.
  - IsSigned=1 → behaviour as above.
  - IsSigned=0 → both operands are zero-extended to WIDTH+1 bits. Q is widened internally to WIDTH+1 bits and count loads WIDTH+1, so latency is WIDTH+2 cycles to Done.
  - Product = low 2*WIDTH bits of the exact unsigned product.
- Not defined: no IsSigned port; signed only; latency exactly as in Behaviour.

Test Plan:
- Reset, then Start with M=3, Q=5 → Busy rises next cycle; Done pulses on cycle 9 after Start; Product=0x000F.
- M=-7 (0xF9), Q=6 → Product=0xFFD6 (-42); M=127, Q=-128 (0x80) → Product=0xC080 (-16256).
- Corner case M=0x80, Q=0x80 → Product=0x4000 (+16384); M=0, Q=0xFF → Product=0x0000.
- Start pulsed with new operands during RUN and during the DONE cycle → ignored; a single Done; Product reflects the first operands only.
- Reset asserted asynchronously at RUN cycle 4 → Busy, Done and Product go to 0 immediately; a new Start after release gives the correct result.
- With BOOTH_UNSIGNED_EN and IsSigned=0: M=0xFF, Q=0xFF → Done on cycle 10; Product=0xFE01 (65025). IsSigned=1 with the same operands → Product=0x0001.
